pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline front end. It drives the enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC enable/redirect. It resolves load-use hazards, instruction-memory and data-memory wait states, and branch mispredict redirects. A mispredict that arrives during a data-memory freeze is held and replayed when the freeze ends. Saturating stall and flush counters are provided for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 72 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: front-end hazard/sequencing control with held mispredict replay and perf counters
module pipe_hazard_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mispredict,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN, FREEZE, FREEZE_PEND} state_t;
    state_t state;
    logic [XLEN-1:0] pend_pc;
    logic load_use, pend, freeze, redirect, stall_lu, stall_im;
    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign pend = state == FREEZE_PEND;
    // every decision is gated by rst so all outputs read 0 while reset is held
    always_comb begin
        freeze         = !rst && !dmem_ready;
        redirect       = !rst && dmem_ready && (pend || ex_mispredict);
        stall_lu       = !rst && dmem_ready && !redirect && load_use;
        stall_im       = !rst && dmem_ready && !redirect && !load_use && !imem_ready;
        pc_en          = !rst && !freeze && !stall_lu && !stall_im;
        if_id_en       = !rst && !freeze && !stall_lu;
        if_id_flush    = redirect || stall_im;
        id_ex_en       = !rst && !freeze;
        id_ex_flush    = redirect || stall_lu;
        redirect_valid = redirect;
        redirect_pc    = redirect ? (pend ? pend_pc : ex_target) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            pend_pc      <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!dmem_ready) begin
                if (!pend && ex_mispredict) begin
                    pend_pc <= ex_target;
                    state   <= FREEZE_PEND;
                end else if (!pend) begin
                    state <= FREEZE;
                end
            end else begin
                state <= RUN;
            end
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect_valid && flush_events != '1)
                flush_events <= flush_events + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations; small counters to reach saturation
module tb_pipe_hazard_ctrl;
    logic clk = 0, rst = 1;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_mispredict = 0;
    logic [31:0] ex_target = 0;
    logic imem_ready = 1, dmem_ready = 1;
    logic pc_en, redirect_valid, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic [31:0] redirect_pc;
    logic [3:0] stall_cycles, flush_events;
    int n_cmp = 0, n_bad = 0;

    pipe_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_en(pc_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // packed {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, redirect_valid}
    task automatic ctl(input string tag, input logic [5:0] exp);
        #1 chk(tag, {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, redirect_valid}, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        ctl("reset_ctl", 6'b000000);
        chk("reset_pc", redirect_pc, 0);
        chk("reset_stall", stall_cycles, 0);
        chk("reset_flush", flush_events, 0);
        cyc(); cyc();
        chk("reset_hold_stall", stall_cycles, 0);
        rst = 0;
        ctl("normal", 6'b110100);
        cyc();
        chk("normal_stall", stall_cycles, 0);
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        ctl("lu_rs1", 6'b000110);
        cyc();
        chk("lu_rs1_stall", stall_cycles, 1);
        ex_rd = 0; id_rs1 = 0;
        ctl("lu_x0", 6'b110100);
        cyc();
        chk("lu_x0_stall", stall_cycles, 1);
        ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_use_rs1 = 0; id_rs1 = 7;
        ctl("lu_rs2", 6'b000110);
        cyc();
        chk("lu_rs2_stall", stall_cycles, 2);
        id_use_rs2 = 0;
        ctl("lu_nouse", 6'b110100);
        ex_mem_read = 0;
        ex_mispredict = 1; ex_target = 32'h100;
        ctl("mp", 6'b111111);
        chk("mp_pc", redirect_pc, 32'h100);
        cyc();
        chk("mp_flush", flush_events, 1);
        ex_mispredict = 0;
        ctl("mp_after", 6'b110100);
        chk("mp_after_pc", redirect_pc, 0);
        dmem_ready = 0; ex_mispredict = 1; ex_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            ctl("frz", 6'b000000);
            chk("frz_pc", redirect_pc, 0);
            cyc();
            ex_target = 32'h300;
        end
        chk("frz_stall", stall_cycles, 5);
        chk("frz_flush", flush_events, 1);
        dmem_ready = 1; ex_mispredict = 0;
        ctl("replay", 6'b111111);
        chk("replay_pc", redirect_pc, 32'h200);
        cyc();
        chk("replay_flush", flush_events, 2);
        chk("replay_stall", stall_cycles, 5);
        ctl("replay_once", 6'b110100);
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        imem_ready = 0; ex_mispredict = 1; ex_target = 32'h40;
        ctl("simul", 6'b111111);
        chk("simul_pc", redirect_pc, 32'h40);
        cyc();
        chk("simul_flush", flush_events, 3);
        chk("simul_stall", stall_cycles, 5);
        ex_mem_read = 0; id_use_rs1 = 0; ex_mispredict = 0;
        for (int i = 0; i < 2; i++) begin
            ctl("imem", 6'b011100);
            cyc();
        end
        chk("imem_stall", stall_cycles, 7);
        imem_ready = 1; dmem_ready = 0;
        ctl("frz_plain", 6'b000000);
        cyc();
        dmem_ready = 1;
        ctl("frz_plain_end", 6'b110100);
        chk("frz_plain_stall", stall_cycles, 8);
        dmem_ready = 0; ex_mispredict = 1; ex_target = 32'h500;
        cyc();
        chk("pend_stall", stall_cycles, 9);
        rst = 1;
        ctl("rst_pend", 6'b000000);
        chk("rst_pend_pc", redirect_pc, 0);
        chk("rst_pend_stall", stall_cycles, 0);
        chk("rst_pend_flush", flush_events, 0);
        cyc();
        rst = 0; dmem_ready = 1; ex_mispredict = 0;
        ctl("rst_no_replay", 6'b110100);
        chk("rst_no_replay_pc", redirect_pc, 0);
        imem_ready = 0;
        repeat (20) cyc();
        chk("sat_stall", stall_cycles, 15);
        imem_ready = 1; ex_mispredict = 1; ex_target = 32'h8;
        repeat (20) cyc();
        chk("sat_flush", flush_events, 15);
        chk("sat_stall_hold", stall_cycles, 15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
